// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master port between icache (requester 0) and dcache (requester 1).
// Define AXI_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (dcache wins).
module axi_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0][ADDR_W-1:0] s_araddr,
    input  logic [1:0][LEN_W-1:0]  s_arlen,
    input  logic [1:0]             s_arvalid,
    output logic [1:0]             s_arready,
    output logic [1:0][DATA_W-1:0] s_rdata,
    output logic [1:0][1:0]        s_rresp,
    output logic [1:0]             s_rvalid,
    output logic [1:0]             s_rlast,
    input  logic [1:0]             s_rready,
    output logic [ADDR_W-1:0]      m_araddr,
    output logic [LEN_W-1:0]       m_arlen,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rvalid,
    input  logic                   m_rlast,
    output logic                   m_rready,
    output logic                   grant,
    output logic                   len_err
);

    // state | meaning
    // IDLE  | no burst outstanding; arbitrate unless cooling down after a burst
    // ADDR  | captured AR held on the master port until m_arready
    // DATA  | R beats steered to the granted requester until rlast
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              len_err_q, len_err_d;
    logic              hold_q, hold_d;
    logic              winner;
    logic              arb_go;
    logic              beat;

`ifdef AXI_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        if (s_arvalid == 2'b11) winner = ~last_q;
        else                    winner = s_arvalid[1];
    end

    always_comb begin
        last_d = last_q;
        if (arb_go) last_d = winner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    assign winner = s_arvalid[1];
`endif

    // rst_n gate keeps the combinational ready at 0 while reset is held.
    assign arb_go = rst_n && (state_q == IDLE) && !hold_q && (s_arvalid != 2'b00);
    assign beat   = (state_q == DATA) && m_rvalid && m_rready;

    always_comb begin
        s_arready = 2'b00;
        if (arb_go) s_arready[winner] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        hold_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    grant_d  = winner;
                    araddr_d = s_araddr[winner];
                    arlen_d  = s_arlen[winner];
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (m_rlast) begin
                        if (beat_cnt_q != arlen_q) len_err_d = 1'b1;
                        state_d = IDLE;
                        hold_d  = 1'b1;
                    end else if (beat_cnt_q == arlen_q) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        m_arvalid = (state_q == ADDR);
        m_araddr  = araddr_q;
        m_arlen   = arlen_q;
        m_rready  = (state_q == DATA) && s_rready[grant_q];
        s_rvalid  = 2'b00;
        s_rlast   = 2'b00;
        s_rdata   = '0;
        s_rresp   = '0;
        if (state_q == DATA) begin
            s_rvalid[grant_q] = m_rvalid;
            s_rlast[grant_q]  = m_rlast;
            s_rdata[grant_q]  = m_rdata;
            s_rresp[grant_q]  = m_rresp;
        end
    end

    assign grant   = grant_q;
    assign len_err = len_err_q;

endmodule
